// File: rtl/reg_pkg.sv
// Shared types and constants for the 8-bit emulator register file slice.
package reg_pkg;

    localparam int NUM_REGS  = 12;
    localparam int REG_WIDTH = 8;
    localparam int CAR_REG   = NUM_REGS - 1;
    localparam int ZERO_REG  = 0;

    typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t            rd;
        logic [REG_WIDTH-1:0] data;
        logic                 car_en;
        logic [REG_WIDTH-1:0] car;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back queue with occupancy count; exposes entries oldest-first.
module wb_fifo
    import reg_pkg::*;
#(
    parameter int depth = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    output wb_entry_t           entries [depth],
    output logic [depth-1:0]    valid,
    output logic                full,
    output logic                empty
);

    localparam int PW = $clog2(depth);

    wb_entry_t        mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Index 0 is the head; higher indices are progressively younger.
    always_comb begin
        for (int unsigned i = 0; i < depth; i++) begin
            entries[i] = mem[rd_ptr + PW'(i)];
            valid[i]   = ((PW+1)'(i) < count);
        end
    end

    assign full  = (count == (PW+1)'(depth));
    assign empty = (count == '0);

endmodule

// File: rtl/reg_writeback.sv
// Write-side queue for the register file: arbitrates ALU/load results, drains
// one entry per cycle, and offers a busy/forwarding lookup for decode.
module reg_writeback
    import reg_pkg::*;
#(
    parameter int num_regs  = NUM_REGS,
    parameter int reg_width = REG_WIDTH,
    parameter int depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_valid,
    input  logic [$clog2(num_regs)-1:0] mem_rd,
    input  logic [reg_width-1:0]        mem_data,
    output logic                        mem_ready,
    input  logic                        alu_valid,
    input  logic [$clog2(num_regs)-1:0] alu_rd,
    input  logic [reg_width-1:0]        alu_data,
    input  logic                        alu_car_en,
    input  logic [reg_width-1:0]        alu_car,
    output logic                        alu_ready,
    input  logic                        hold,
    output logic                        write,
    output logic [$clog2(num_regs)-1:0] rd_addr,
    output logic [reg_width-1:0]        rd_in,
    output logic                        write_car,
    output logic [reg_width-1:0]        car_in,
    input  logic [$clog2(num_regs)-1:0] q_addr,
    output logic                        q_busy,
    output logic [reg_width-1:0]        q_data
);

    wb_entry_t        entries [depth];
    logic [depth-1:0] valid;
    logic             full;
    logic             empty;
    logic             mem_fire;
    logic             alu_fire;
    logic             push;
    logic             pop;
    wb_entry_t        new_entry;
    wb_entry_t        head;

    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        new_entry = '0;
        if (mem_fire) begin
            new_entry.rd   = mem_rd;
            new_entry.data = mem_data;
        end else begin
            new_entry.rd     = alu_rd;
            new_entry.data   = alu_data;
            new_entry.car_en = alu_car_en;
            new_entry.car    = alu_car;
        end
    end

    // Entries with nothing to write are accepted but never enqueued.
    assign push = (mem_fire || alu_fire) &&
                  !(new_entry.rd == reg_addr_t'(ZERO_REG) && !new_entry.car_en);
    assign pop  = !empty && !hold;

    wb_fifo #(.depth(depth)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .entries    (entries),
        .valid      (valid),
        .full       (full),
        .empty      (empty)
    );

    assign head = empty ? '0 : entries[0];

    // Write strobes are masked while reset is asserted so a flushed queue never pulses.
    assign write     = pop && rst_n && (head.rd != reg_addr_t'(ZERO_REG));
    assign write_car = pop && rst_n && head.car_en;
    assign rd_addr   = head.rd;
    assign rd_in     = head.data;
    assign car_in    = head.car;

    always_comb begin
        q_busy = 1'b0;
        q_data = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            if (valid[i]) begin
                if (q_addr != reg_addr_t'(ZERO_REG) && entries[i].rd == q_addr) begin
                    q_busy = 1'b1;
                    q_data = entries[i].data;
                end
                if (entries[i].car_en && q_addr == reg_addr_t'(CAR_REG)) begin
                    q_busy = 1'b1;
                    q_data = entries[i].car;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed-vector bench for reg_writeback with immediate-assertion checks.
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_valid;
    logic [3:0] mem_rd;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       alu_valid;
    logic [3:0] alu_rd;
    logic [7:0] alu_data;
    logic       alu_car_en;
    logic [7:0] alu_car;
    logic       alu_ready;
    logic       hold;
    logic       write;
    logic [3:0] rd_addr;
    logic [7:0] rd_in;
    logic       write_car;
    logic [7:0] car_in;
    logic [3:0] q_addr;
    logic       q_busy;
    logic [7:0] q_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback #(.num_regs(12), .reg_width(8), .depth(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_car_en (alu_car_en),
        .alu_car    (alu_car),
        .alu_ready  (alu_ready),
        .hold       (hold),
        .write      (write),
        .rd_addr    (rd_addr),
        .rd_in      (rd_in),
        .write_car  (write_car),
        .car_in     (car_in),
        .q_addr     (q_addr),
        .q_busy     (q_busy),
        .q_data     (q_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alu_offer(input logic [3:0] rd, input logic [7:0] d,
                             input logic ce, input logic [7:0] c);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d; alu_car_en = ce; alu_car = c;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_car_en = 1'b0; alu_car = '0;
        hold = 1'b0; q_addr = '0;
        tick(); tick();
        rst_n = 1'b1; #1;
        check("rst_write", write, 0);
        check("rst_write_car", write_car, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_in", rd_in, 0);
        check("rst_car_in", car_in, 0);
        check("rst_q_busy", q_busy, 0);
        check("rst_q_data", q_data, 0);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_alu_ready", alu_ready, 1);

        // Single ALU write, one-cycle latency
        alu_offer(4'd3, 8'h5A, 1'b0, 8'h00);
        check("t1_alu_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0; #1;
        check("t1_write", write, 1);
        check("t1_rd_addr", rd_addr, 3);
        check("t1_rd_in", rd_in, 8'h5A);
        check("t1_write_car", write_car, 0);
        tick();
        check("t1_idle", write, 0);

        // Load beats ALU; order preserved
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 8'h11;
        alu_offer(4'd4, 8'h22, 1'b0, 8'h00);
        check("t2_mem_ready", mem_ready, 1);
        check("t2_alu_ready", alu_ready, 0);
        tick(); mem_valid = 1'b0; #1;
        check("t2_alu_ready2", alu_ready, 1);
        check("t2_w1", write, 1);
        check("t2_w1_addr", rd_addr, 2);
        check("t2_w1_data", rd_in, 8'h11);
        tick(); alu_valid = 1'b0; #1;
        check("t2_w2", write, 1);
        check("t2_w2_addr", rd_addr, 4);
        check("t2_w2_data", rd_in, 8'h22);
        tick();
        check("t2_idle", write, 0);

        // Fill under hold, fifth offer stalls, then drain
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_offer(4'(i), 8'(i * 16), 1'b0, 8'h00);
            tick();
        end
        alu_offer(4'd5, 8'h50, 1'b0, 8'h00);
        check("t3_full_alu_ready", alu_ready, 0);
        check("t3_full_mem_ready", mem_ready, 0);
        check("t3_hold_write", write, 0);
        tick();
        check("t3_stall", alu_ready, 0);
        hold = 1'b0; #1;
        check("t3_pop_full_ready", alu_ready, 0);
        check("t3_p1", write, 1);
        check("t3_p1_addr", rd_addr, 1);
        tick();
        check("t3_ready_back", alu_ready, 1);
        check("t3_p2_addr", rd_addr, 2);
        check("t3_p2", write, 1);
        tick(); alu_valid = 1'b0; #1;
        check("t3_p3_addr", rd_addr, 3);
        tick();
        check("t3_p4_addr", rd_addr, 4);
        check("t3_p4_data", rd_in, 8'h40);
        tick();
        check("t3_p5_addr", rd_addr, 5);
        check("t3_p5_data", rd_in, 8'h50);
        tick();
        check("t3_idle", write, 0);

        // Drop rule and carry-only entries
        alu_offer(4'd0, 8'h77, 1'b0, 8'h00);
        check("t4_drop_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0; #1;
        check("t4_drop_write", write, 0);
        check("t4_drop_wcar", write_car, 0);
        alu_offer(4'd0, 8'h00, 1'b1, 8'h01);
        tick(); alu_valid = 1'b0; #1;
        check("t4_car_write", write, 0);
        check("t4_car_wcar", write_car, 1);
        check("t4_car_in", car_in, 8'h01);
        tick();
        check("t4_car_idle", write_car, 0);

        // Carry register written by both ports; lookup returns car
        hold = 1'b1;
        alu_offer(4'd11, 8'hAA, 1'b1, 8'hBB);
        tick(); alu_valid = 1'b0; q_addr = 4'd11; #1;
        check("t4c_busy", q_busy, 1);
        check("t4c_qdata", q_data, 8'hBB);
        hold = 1'b0; #1;
        check("t4c_write", write, 1);
        check("t4c_wcar", write_car, 1);
        check("t4c_addr", rd_addr, 11);
        tick();

        // Forwarding of youngest value
        hold = 1'b1;
        alu_offer(4'd5, 8'h10, 1'b0, 8'h00);
        tick();
        alu_offer(4'd5, 8'h20, 1'b0, 8'h00);
        tick(); alu_valid = 1'b0;
        q_addr = 4'd5; #1;
        check("t5_busy5", q_busy, 1);
        check("t5_data5", q_data, 8'h20);
        q_addr = 4'd6; #1;
        check("t5_busy6", q_busy, 0);
        check("t5_data6", q_data, 0);
        q_addr = 4'd0; #1;
        check("t5_busy0", q_busy, 0);
        q_addr = 4'd11; #1;
        check("t5_busy11", q_busy, 0);
        hold = 1'b0; q_addr = 4'd5; #1;
        check("t5_head_match", q_busy, 1);
        tick(); tick();
        check("t5_drained", q_busy, 0);

        // Reset with entries queued
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_offer(4'(i), 8'(i), 1'b1, 8'h0F);
            tick();
        end
        alu_valid = 1'b0;
        rst_n = 1'b0; hold = 1'b0; #1;
        check("t6_rst_cycle_write", write, 0);
        check("t6_rst_cycle_wcar", write_car, 0);
        tick();
        rst_n = 1'b1; #1;
        check("t6_write", write, 0);
        check("t6_wcar", write_car, 0);
        check("t6_mem_ready", mem_ready, 1);
        check("t6_alu_ready", alu_ready, 1);
        for (int unsigned a = 0; a < 12; a++) begin
            q_addr = 4'(a); #1;
            check("t6_q_busy", q_busy, 0);
        end
        tick();
        check("t6_write_next", write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side companion of the 8-bit emulator register file.
- Accepts register results from the ALU and memory-load paths and buffers them in a 4-entry in-order queue.
- Drains one entry per cycle into the register file's write port (rd_addr/rd_in/write) and carry port (car_in/write_car).
- Exposes a busy/forwarding lookup so decode can stall or bypass on registers with pending writes.

Parameters:
- num_regs, 12, number of architectural registers; register num_regs-1 is the carry register.
- reg_width, 8, data width of registers and carry value.
- depth, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_valid  in  1  load result offered.
- mem_rd  in  $clog2(num_regs)  load destination register.
- mem_data  in  reg_width  load data.
- mem_ready  out  1  load result accepted this cycle.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  $clog2(num_regs)  ALU destination register.
- alu_data  in  reg_width  ALU result.
- alu_car_en  in  1  ALU result also updates the carry register.
- alu_car  in  reg_width  carry value.
- alu_ready  out  1  ALU result accepted this cycle.
- hold  in  1  freezes draining (single-step/debug); enqueue still allowed.
- write  out  1  register file write enable.
- rd_addr  out  $clog2(num_regs)  register file write address.
- rd_in  out  reg_width  register file write data.
- write_car  out  1  carry register write enable.
- car_in  out  reg_width  carry write data.
- q_addr  in  $clog2(num_regs)  lookup register address.
- q_busy  out  1  q_addr has at least one queued write.
- q_data  out  reg_width  youngest queued value for q_addr; 0 when q_busy=0.

Behaviour:
- Reset (rst_n=0 at an edge): queue empty, pointers and count = 0. Consequently write=0, write_car=0, rd_addr=0, rd_in=0, car_in=0, q_busy=0, q_data=0. Both readies=1 after reset.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at a rising edge.
  - Readies are combinational from count and the other source's valid only, never from own valid.
- Arbitration, fixed priority, at most one enqueue per cycle:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
- Full: count==depth forces both readies low, even if a pop occurs in the same cycle. There is no push/pop bypass when full.
- Entry contents: {rd, data, car_en, car}. Load entries set car_en=0.
- Drop rule: an accepted entry with rd==0 and car_en==0 is discarded (handshake completes, nothing enqueued). Register 0 is never written.
- Drain (combinational from the queue head):
  - When not empty and hold=0: write = (head.rd!=0); rd_addr=head.rd; rd_in=head.data; write_car=head.car_en; car_in=head.car. The head pops at the next edge.
  - When empty or hold=1: write=0, write_car=0; address and data outputs hold the head contents, or 0 when empty.
- Latency: result accepted at edge N is committed to the register file at edge N+1 when the queue was empty and hold=0. Otherwise it commits in strict FIFO order, one entry per unheld cycle.
- Simultaneous push and pop (not full): both occur; count unchanged.
- Carry conflict: an entry with rd==num_regs-1 and car_en=1 drives both writes in the same cycle. The carry port has priority in the register file, so the net result is car. Lookup reports car for that register (see below).
- Lookup (combinational):
  - q_busy = 1 if any valid entry has rd==q_addr (q_addr!=0), or car_en=1 with q_addr==num_regs-1.
  - q_data comes from the youngest matching entry. Within one entry, car takes precedence over data for register num_regs-1.
  - The head entry being written this cycle still matches, which covers the register file's registered read.
- Reset mid-operation: all queued entries are discarded, with no write pulses in the reset cycle or the following cycle.

Decomposition:
- Shared package reg_pkg:
  - Constants NUM_REGS=12, REG_WIDTH=8, CAR_REG=NUM_REGS-1, ZERO_REG=0.
  - Typedef reg_addr_t.
  - Packed struct wb_entry_t {rd, data, car_en, car}.
- One sub-module wb_fifo (depth-parameterised circular buffer with count). It exposes all entries plus a valid vector for the lookup scan.
- Arbitration, drop rule and lookup stay in reg_writeback.

Test Plan:
- Reset then single ALU write: alu rd=3, data=0x5A, car_en=0 -> alu_ready=1; next cycle write=1, rd_addr=3, rd_in=0x5A, write_car=0; following cycle write=0.
- Priority: mem (rd=2, 0x11) and alu (rd=4, 0x22) valid together -> mem accepted, alu_ready=0; alu accepted next cycle; writes appear in order r2=0x11 then r4=0x22.
- Fill with hold=1: 4 ALU pushes to r1..r4 -> readies low with count=4; a 5th offer stalls; release hold -> 4 consecutive write pulses, readies return high after the first pop.
- Drop/carry: rd=0 with car_en=0 -> no write ever issued; rd=0 with car_en=1, car=0x01 -> write=0, write_car=1, car_in=0x01.
- Forwarding: hold=1; push r5=0x10, then r5=0x20 -> q_addr=5 gives q_busy=1, q_data=0x20; q_addr=6 gives q_busy=0, q_data=0; q_addr=0 gives q_busy=0.
- Reset mid-queue: 3 entries queued, rst_n=0 for one edge -> write=0 and write_car=0 afterwards, q_busy=0 for all addresses, readies=1.
